// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a word-addressed register array,
// with programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
   parameter int          AW        = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          WAIT_CYC  = 0
) (
   input  logic        hclk,
   input  logic        hrest,
   input  logic        hsel,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready_in,
   output logic        hready_out,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;
   localparam logic [2:0] CNT_LOAD = WAIT_CYC > 0 ? 3'(WAIT_CYC - 1) : 3'd0;
   logic [31:0]   mem [2**AW];
   state_t        state, state_nxt;
   logic [2:0]    cnt;
   logic          r_write;
   logic [AW+1:0] r_addr;
   logic [1:0]    r_size;
   logic          accept, legal;
   logic [3:0]    be;
   assign accept = hsel & htrans[1] & hready_in & hready_out;
   assign legal  = haddr[31:AW+2] == BASE_ADDR[31:AW+2] && !hsize[2] && hsize[1:0] != 2'b11 &&
                   !(hsize[1:0] == 2'b01 && haddr[0]) && !(hsize[1:0] == 2'b10 && haddr[1:0] != 2'b00);
   always_comb begin
      state_nxt = !accept ? S_IDLE : !legal ? S_ERR1 : (WAIT_CYC > 0 ? S_WAIT : S_DONE);
      if (state == S_WAIT) state_nxt = cnt == 3'd0 ? S_DONE : S_WAIT;
      else if (state == S_ERR1) state_nxt = S_ERR2;
   end
   always_ff @(posedge hclk or posedge hrest) begin
      if (hrest) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_size  <= 2'b00;
      end else begin
         state <= state_nxt;
         cnt   <= state == S_WAIT ? cnt - 3'd1 : CNT_LOAD;
         if (accept) begin
            r_write <= hwrite;
            r_addr  <= haddr[AW+1:0];
            r_size  <= hsize[1:0];
         end
      end
   end
   always_comb be = r_size == 2'b10 ? 4'hf : r_size == 2'b01 ? (r_addr[1] ? 4'hc : 4'h3) : 4'b0001 << r_addr[1:0];
   // memory is deliberately left out of reset; reset only kills the pending write via state
   always_ff @(posedge hclk) begin
      if (state == S_DONE && r_write)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[r_addr[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
   end
   assign hready_out = !(state == S_WAIT || state == S_ERR1);
   assign hresp      = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
   assign hrdata     = (state == S_DONE && !r_write) ? mem[r_addr[AW+1:2]] : 32'h0;
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) with an internal word-addressed register-array memory.
- It is the far end of the bench-side AHB initiator: it accepts htrans/hwrite/haddr/hwdata/hsize and returns hready_out/hresp/hrdata.
- Wait-state insertion is programmable, so the initiator's stall handling is exercised.
- A two-cycle ERROR response covers illegal accesses.

Parameters:
- AW, 10, word-address width; memory depth 2^AW words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^AW.
- WAIT_CYC, 0, wait states inserted per OKAY transfer (legal range 0..7).

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hrest  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- haddr  in  32  byte address.
- hsize  in  3  000 byte, 001 half, 010 word; others illegal.
- hwdata  in  32  write data, valid in data phase.
- hready_in  in  1  bus-wide HREADY; address phase is qualified by it.
- hready_out  out  1  slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset values while hrest is high: state IDLE, hready_out=1, hresp=00, hrdata=0, wait counter 0, pending access cleared. Memory contents are not reset.
- Address-phase accept happens when hsel & htrans[1] & hready_in at a rising edge.
  - Register: write flag, haddr, hsize, and a legality flag.
  - The next cycle is the data phase.
  - htrans IDLE/BUSY, or hsel=0, accepts nothing and leaves the slave in IDLE with an OKAY zero-wait response.
- Legality (evaluated on address-phase values):
  - haddr lies in [BASE_ADDR, BASE_ADDR+4*2^AW-1].
  - hsize <= 010.
  - Natural alignment: half needs haddr[0]=0; word needs haddr[1:0]=00.
  - Any failure makes the access illegal.
- States:
  - IDLE: hready_out=1, hresp=00.
    - On a legal accept: go to WAIT if WAIT_CYC>0, else go to DONE.
    - On an illegal accept: go to ERR1.
  - WAIT: hready_out=0, hresp=00.
    - The counter loads WAIT_CYC-1 on entry and decrements each cycle.
    - Leave for DONE when the counter is 0, so there are exactly WAIT_CYC low cycles.
  - DONE: the completing cycle, hready_out=1, hresp=00.
    - Write: lanes selected by the registered hsize and haddr[1:0] are written from hwdata at this cycle's rising edge.
    - Read: hrdata = mem[registered haddr[AW+1:2]] combinationally, full 32-bit word regardless of hsize.
    - A new accept in the same cycle (pipelined) goes to WAIT, DONE or ERR1 per the rules above; otherwise go to IDLE.
  - ERR1: hready_out=0, hresp=01. Always go to ERR2.
  - ERR2: hready_out=1, hresp=01.
    - No memory write; hrdata=0.
    - An accept here is handled as from IDLE (the master may also drive IDLE after an error).
- Byte lanes:
  - byte: lane haddr[1:0].
  - half: lanes {haddr[1],0} and {haddr[1],1}.
  - word: all four lanes.
- hrdata is 0 in every cycle except DONE of a read.
- Back-to-back write then read to the same word: the read's data phase returns the newly written value.
  - The write commits at the edge that ends its DONE cycle, before the read's DONE cycle.
- hready_in=0 during another slave's data phase: no accept occurs; state is unaffected.
- hwdata is only sampled in DONE, so data held during WAIT may change until then.
- Reset asserted mid-transfer:
  - Outputs return to reset values immediately (asynchronously).
  - Any pending write is discarded; memory words already written keep their values.
- Aligned BASE_ADDR means the index is haddr[AW+1:2] with no subtraction; the range check compares haddr[31:AW+2] with BASE_ADDR[31:AW+2].

Test Plan:
1. WAIT_CYC=0: NONSEQ word write 0x0000_0010 = 0xDEADBEEF, then a pipelined read of the same address → hready_out stays 1, read DONE returns hrdata=0xDEADBEEF, hresp=00.
2. Byte write 0xA5 to 0x13 after a word write of 0x11223344 to 0x10 → a word read of 0x10 returns 0xA5223344. Half write 0xBEEF to 0x10 → returns 0xA522BEEF.
3. WAIT_CYC=3: read of 0x20 → exactly 3 cycles of hready_out=0, then 1 cycle hready_out=1 with valid data; hwdata changed during wait on a write is ignored until DONE.
4. Out-of-range word read at BASE_ADDR+0x1000 (AW=10), and an unaligned word at 0x02 → each gives cycle 1 hready_out=0/hresp=01, cycle 2 hready_out=1/hresp=01, memory unchanged, hrdata=0.
5. htrans=BUSY, hsel=0, or hready_in=0 with NONSEQ → no state change, hready_out=1, hresp=00, no write.
6. Assert hrest during WAIT of a write to 0x30 (old value 0x1) → hready_out=1, hresp=00 immediately; a later read of 0x30 returns 0x1.
